// File: rtl/sifh_hist_scheduler.sv
// SiFH histogram RAM sequencer: CLEAR -> ACCUM (pipelined increment with forwarding)
// -> DRAIN -> READOUT (read-and-clear stream) -> ACCUM.
module sifh_hist_scheduler #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned FRM_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              hit_valid,
  input  logic [ADDR_W-1:0] hit_addr,
  output logic              hit_ready,
  input  logic              frame_end,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [CNT_W-1:0]  ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [CNT_W-1:0]  ram_wdata,
  output logic              ro_valid,
  output logic [ADDR_W-1:0] ro_addr,
  output logic [CNT_W-1:0]  ro_data,
  input  logic              ro_ready,
  output logic              busy,
  output logic              sat_flag,
  output logic [FRM_W-1:0]  frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_CLEAR, S_ACCUM, S_DRAIN1, S_DRAIN2, S_RO_RD, S_RO_WAIT
  } state_t;

  state_t              state_q, state_n;
  logic                clr_run_q;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic [ADDR_W-1:0]   k_q;
  logic                hit_ready_q;
  logic                s1_valid_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [CNT_W-1:0]    wr_data_q;
  logic                ro_valid_q, ro_first_q;
  logic [ADDR_W-1:0]   ro_addr_q;
  logic [CNT_W-1:0]    ro_data_q;
  logic                sat_q;
  logic [FRM_W-1:0]    frame_cnt_q;

  logic                accept, sat_hit, ro_hs;
  logic [CNT_W-1:0]    base;

  always_comb begin
    state_n   = state_q;
    ram_re    = 1'b0;
    ram_raddr = '0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    accept    = 1'b0;
    sat_hit   = 1'b0;
    ro_hs     = 1'b0;
    base      = '0;

    // Second stage of the increment: the previous cycle's write may not be visible in ram_rdata yet
    if (s1_valid_q) begin
      base      = (wr_q && wr_addr_q == s1_addr_q) ? wr_data_q : ram_rdata;
      ram_we    = 1'b1;
      ram_waddr = s1_addr_q;
      if (base == CNT_MAX) begin
        sat_hit   = 1'b1;
        ram_wdata = base;
      end else begin
        ram_wdata = base + 1'b1;
      end
    end

    case (state_q)
      S_CLEAR: begin
        if (clr_run_q) begin
          ram_we    = 1'b1;
          ram_waddr = clr_idx_q;
          ram_wdata = '0;
          if (clr_idx_q == LAST) state_n = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (hit_ready_q && hit_valid && ({1'b0, hit_addr} < DEPTH_X)) begin
          accept    = 1'b1;
          ram_re    = 1'b1;
          ram_raddr = hit_addr;
        end
        if (frame_end) state_n = S_DRAIN1;
      end
      S_DRAIN1: state_n = S_DRAIN2;
      S_DRAIN2: state_n = S_RO_RD;
      S_RO_RD: begin
        ram_re    = 1'b1;
        ram_raddr = k_q;
        state_n   = S_RO_WAIT;
      end
      S_RO_WAIT: begin
        if (ro_valid_q && ro_ready) begin
          ro_hs     = 1'b1;
          ram_we    = 1'b1;
          ram_waddr = k_q;
          ram_wdata = '0;
          state_n   = (k_q == LAST) ? S_ACCUM : S_RO_RD;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_CLEAR;
      clr_run_q   <= 1'b0;
      clr_idx_q   <= '0;
      k_q         <= '0;
      hit_ready_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      wr_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ro_valid_q  <= 1'b0;
      ro_first_q  <= 1'b0;
      ro_addr_q   <= '0;
      ro_data_q   <= '0;
      sat_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      hit_ready_q <= (state_n == S_ACCUM);
      s1_valid_q  <= accept;
      if (accept) s1_addr_q <= hit_addr;
      wr_q        <= ram_we;
      wr_addr_q   <= ram_waddr;
      wr_data_q   <= ram_wdata;

      if (state_q == S_CLEAR) begin
        if (!clr_run_q)              clr_run_q <= 1'b1;
        else if (clr_idx_q != LAST)  clr_idx_q <= clr_idx_q + 1'b1;
      end

      if (sat_hit) sat_q <= 1'b1;

      if (state_q == S_RO_RD) begin
        ro_valid_q <= 1'b1;
        ro_first_q <= 1'b1;
        ro_addr_q  <= k_q;
      end

      // RAM data is only guaranteed in the first wait cycle, so it is held from then on
      if (state_q == S_RO_WAIT) begin
        if (ro_first_q) begin
          ro_data_q  <= ram_rdata;
          ro_first_q <= 1'b0;
        end
        if (ro_hs) begin
          ro_valid_q <= 1'b0;
          if (k_q == LAST) begin
            k_q         <= '0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            sat_q       <= 1'b0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
      end
    end
  end

  assign hit_ready = hit_ready_q;
  assign ro_valid  = ro_valid_q;
  assign ro_addr   = ro_addr_q;
  assign ro_data   = ro_first_q ? ram_rdata : ro_data_q;
  assign busy      = (state_q != S_ACCUM);
  assign sat_flag  = sat_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sifh_hist_scheduler.sv
// Directed bench for sifh_hist_scheduler with a read-first, 1-cycle-latency dual-port RAM.
module tb_sifh_hist_scheduler;

  logic        clk = 1'b0;
  logic        res;
  logic        hit_valid;
  logic [9:0]  hit_addr;
  logic        hit_ready;
  logic        frame_end;
  logic        ram_re;
  logic [9:0]  ram_raddr;
  logic [7:0]  ram_rdata;
  logic        ram_we;
  logic [9:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic        ro_valid;
  logic [9:0]  ro_addr;
  logic [7:0]  ro_data;
  logic        ro_ready;
  logic        busy;
  logic        sat_flag;
  logic [15:0] frame_cnt;

  logic        poke_en;
  logic [9:0]  poke_addr;
  logic [7:0]  poke_data;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  exp_mem [0:1023];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  sifh_hist_scheduler #(.ADDR_W(10), .DEPTH(1024), .CNT_W(8), .FRM_W(16)) dut (
    .clk(clk), .res(res),
    .hit_valid(hit_valid), .hit_addr(hit_addr), .hit_ready(hit_ready),
    .frame_end(frame_end),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ro_valid(ro_valid), .ro_addr(ro_addr), .ro_data(ro_data), .ro_ready(ro_ready),
    .busy(busy), .sat_flag(sat_flag), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en)     mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    ram_rdata = '0;
    res = 1'b1; hit_valid = 1'b0; hit_addr = '0; frame_end = 1'b0; ro_ready = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 8'd0;
    exp_mem[5] = 8'd1; exp_mem[7] = 8'd3; exp_mem[9] = 8'd255; exp_mem[1023] = 8'd1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {busy, hit_ready, ram_we, ram_re, ro_valid, sat_flag},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_vals", {frame_cnt, ro_addr, ro_data}, '0);

    // T1: full clear
    next_drive(); res = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_we && n < 4);
    chk("clr_start", ram_we, 1);
    for (int i = 0; i < 1024; i++) begin
      chk("clr_word", {busy, ram_we, ram_wdata, ram_waddr}, {1'b1, 1'b1, 8'd0, 10'(i)});
      @(negedge clk);
    end
    chk("accum_entry", {busy, hit_ready, ram_we}, {1'b0, 1'b1, 1'b0});

    // T2: single hit to bin 5
    next_drive(); hit_valid = 1'b1; hit_addr = 10'd5;
    @(negedge clk);
    chk("t2_read", {ram_re, ram_raddr, ram_we}, {1'b1, 10'd5, 1'b0});
    next_drive(); hit_valid = 1'b0;
    @(negedge clk);
    chk("t2_write", {ram_re, ram_we, ram_waddr, ram_wdata}, {1'b0, 1'b1, 10'd5, 8'd1});

    // T3: back-to-back hits to bin 7 need forwarding
    for (int c = 0; c < 4; c++) begin
      next_drive(); hit_valid = (c < 3); hit_addr = 10'd7;
      @(negedge clk);
      chk("t3_read", {ram_re, ram_raddr}, (c < 3) ? {1'b1, 10'd7} : {1'b0, 10'd0});
      if (c > 0) chk("t3_write", {ram_we, ram_waddr, ram_wdata}, {1'b1, 10'd7, 8'(c)});
    end
    next_drive(); hit_valid = 1'b0;
    @(negedge clk);
    chk("t3_idle", {ram_we, ram_re, sat_flag}, 3'b000);

    // T4: saturation at bin 9
    poke_en = 1'b1; poke_addr = 10'd9; poke_data = 8'd255;
    next_drive(); poke_en = 1'b0; hit_valid = 1'b1; hit_addr = 10'd9;
    @(negedge clk);
    chk("t4_read", {ram_re, ram_raddr}, {1'b1, 10'd9});
    next_drive(); hit_valid = 1'b0;
    @(negedge clk);
    chk("t4_write", {ram_we, ram_waddr, ram_wdata}, {1'b1, 10'd9, 8'd255});
    next_drive();
    @(negedge clk);
    chk("t4_sat", sat_flag, 1);

    // T5: frame_end with a same-cycle hit on the top bin, then stalled readout
    next_drive(); hit_valid = 1'b1; hit_addr = 10'd1023; frame_end = 1'b1;
    @(negedge clk);
    chk("t5_last_hit", {busy, hit_ready, ram_re, ram_raddr}, {1'b0, 1'b1, 1'b1, 10'd1023});
    next_drive(); frame_end = 1'b0; hit_addr = 10'd3;
    @(negedge clk);
    chk("t5_drain1", {busy, hit_ready, ram_re, ram_we, ram_waddr, ram_wdata},
        {1'b1, 1'b0, 1'b0, 1'b1, 10'd1023, 8'd1});
    next_drive(); hit_valid = 1'b0;
    @(negedge clk);
    chk("t5_drain2", {busy, ram_re, ram_we}, {1'b1, 1'b0, 1'b0});

    for (int b = 0; b < 1024; b++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!ro_valid && n < 8);
      chk("ro_wait", ro_valid, 1);
      for (int s = 0; s < 5; s++) begin
        if (s > 0) @(negedge clk);
        chk("ro_stall", {ro_valid, ram_we, ram_re, ro_addr, ro_data},
            {1'b1, 1'b0, 1'b0, 10'(b), exp_mem[b]});
      end
      next_drive(); ro_ready = 1'b1;
      @(negedge clk);
      chk("ro_hs", {ro_valid, ram_we, ram_re, ram_waddr, ram_wdata, ro_addr, ro_data},
          {1'b1, 1'b1, 1'b0, 10'(b), 8'd0, 10'(b), exp_mem[b]});
      if (b == 1023) chk("ro_sat_held", {sat_flag, busy}, 2'b11);
      next_drive(); ro_ready = 1'b0;
    end
    @(negedge clk);
    chk("t5_done", {busy, hit_ready, sat_flag, ro_valid, frame_cnt},
        {1'b0, 1'b1, 1'b0, 1'b0, 16'd1});

    // Bin 7 was cleared by the readout
    next_drive(); hit_valid = 1'b1; hit_addr = 10'd7;
    next_drive(); hit_valid = 1'b0;
    @(negedge clk);
    chk("post_clear", {ram_we, ram_waddr, ram_wdata}, {1'b1, 10'd7, 8'd1});

    // T6: reset mid-readout
    next_drive(); frame_end = 1'b1;
    next_drive(); frame_end = 1'b0; ro_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(ro_valid && ro_addr == 10'd300) && n < 3000);
    chk("t6_reach", {ro_valid, ro_addr}, {1'b1, 10'd300});
    next_drive(); res = 1'b1; ro_ready = 1'b0;
    @(negedge clk);
    chk("t6_rst_outs", {busy, hit_ready, ram_we, ram_re, ro_valid, sat_flag},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("t6_rst_vals", {frame_cnt, ro_addr, ro_data}, '0);
    next_drive(); res = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_we && n < 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_clr", {busy, ram_we, ram_wdata, ram_waddr, frame_cnt},
          {1'b1, 1'b1, 8'd0, 10'(i), 16'd0});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
